// File: rtl/dsp_share_sched_pkg.sv
// Shared constants and helpers for the DSP-sharing scheduler.
// Stage indices map the block's stage valids onto DSP stages s0..s3.
package dsp_share_sched_pkg;

  localparam int STAGES = 4;

  localparam int STG_S0 = 0;
  localparam int STG_S1 = 1;
  localparam int STG_S2 = 2;
  localparam int STG_S3 = 3;

  typedef logic [STAGES-1:0] stage_vec_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_share_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr with wrap.
// The pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  hi;

  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) begin
      hi[i] = req[i] && (i >= int'(ptr_q));
    end
  end

  // Lowest request overall is the wrap-around fallback;
  // lowest request at/above ptr overrides it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (hi[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (int'(grant_idx) == N - 1) ptr_d = '0;
      else ptr_d = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dsp_share_sched.sv
// Shares one (a+d)*b+c DSP among requesters: arbitration, operand
// muxing, per-stage clock enables, ID tracking and result handshake.
module dsp_share_sched
  import dsp_share_sched_pkg::*;
#(
  parameter int req_n            = 4,
  parameter int id_width         = 2,
  parameter int op_a_width       = 16,
  parameter int op_b_width       = 16,
  parameter int op_c_width       = 32,
  parameter int op_d_width       = 16,
  parameter int output_width     = 32,
  parameter int simulation_delay = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [req_n-1:0]              s_valid,
  output logic [req_n-1:0]              s_ready,
  input  logic [req_n*op_a_width-1:0]   s_op_a,
  input  logic [req_n*op_b_width-1:0]   s_op_b,
  input  logic [req_n*op_c_width-1:0]   s_op_c,
  input  logic [req_n*op_d_width-1:0]   s_op_d,
  output logic [op_a_width-1:0]         dsp_op_a,
  output logic [op_b_width-1:0]         dsp_op_b,
  output logic [op_d_width-1:0]         dsp_op_d,
  output logic [op_c_width-1:0]         dsp_op_c,
  output logic                          dsp_ce_s0,
  output logic                          dsp_ce_s1,
  output logic                          dsp_ce_s2,
  output logic                          dsp_ce_s3,
  input  logic [output_width-1:0]       dsp_res,
  input  logic                          dsp_pd,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [output_width-1:0]       m_res,
  output logic                          m_pd,
  output logic [id_width-1:0]           m_id,
  output logic                          busy
);

  if (id_width < clog2(req_n) || req_n < 2 || req_n > 8 ||
      simulation_delay < 0) begin : g_cfg_err
    $error("dsp_share_sched: invalid parameter set");
  end

  stage_vec_t          v_q, v_d;
  logic                mv1, mv2, mv3, mv4, free1;
  logic [req_n-1:0]    grant;
  logic [id_width-1:0] gidx;
  logic [id_width-1:0] tag_q [STAGES];
  logic [op_c_width-1:0] c_sel, c1_q, c2_q;

  rr_arbiter #(
    .N  (req_n),
    .IW (id_width)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (s_valid),
    .accept    (mv1),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // Reset gates free1 so no CE or s_ready fires while rst_n is low.
  always_comb begin
    mv4   = v_q[STG_S3 - 1] & (~v_q[STG_S3] | m_ready);
    mv3   = v_q[STG_S1] & (~v_q[STG_S2] | mv4);
    mv2   = v_q[STG_S0] & (~v_q[STG_S1] | mv3);
    free1 = rst_n & (~v_q[STG_S0] | mv2);
    mv1   = (|(s_valid & grant)) & free1;
  end

  always_comb begin
    v_d         = v_q;
    v_d[STG_S0] = mv1 | (v_q[STG_S0] & ~mv2);
    v_d[STG_S1] = mv2 | (v_q[STG_S1] & ~mv3);
    v_d[STG_S2] = mv3 | (v_q[STG_S2] & ~mv4);
    v_d[STG_S3] = mv4 | (v_q[STG_S3] & ~m_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
    end else begin
      v_q <= v_d;
      if (mv1) tag_q[STG_S0] <= gidx;
      if (mv2) tag_q[STG_S1] <= tag_q[STG_S0];
      if (mv3) tag_q[STG_S2] <= tag_q[STG_S1];
      if (mv4) tag_q[STG_S3] <= tag_q[STG_S2];
    end
  end

  always_comb begin
    dsp_op_a = '0;
    dsp_op_b = '0;
    dsp_op_d = '0;
    c_sel    = '0;
    for (int i = 0; i < req_n; i++) begin
      if (gidx == id_width'(i)) begin
        dsp_op_a = s_op_a[i*op_a_width +: op_a_width];
        dsp_op_b = s_op_b[i*op_b_width +: op_b_width];
        dsp_op_d = s_op_d[i*op_d_width +: op_d_width];
        c_sel    = s_op_c[i*op_c_width +: op_c_width];
      end
    end
  end

  // C rides two local registers so it lands with the multiplier stage.
  always_ff @(posedge clk) begin
    if (mv1) c1_q <= c_sel;
    if (mv2) c2_q <= c1_q;
  end

  assign dsp_op_c  = c2_q;
  assign dsp_ce_s0 = mv1;
  assign dsp_ce_s1 = mv2;
  assign dsp_ce_s2 = mv3;
  assign dsp_ce_s3 = mv4;
  assign s_ready   = grant & {req_n{free1}};
  assign m_valid   = v_q[STG_S3];
  assign m_id      = tag_q[STG_S3];
  assign m_res     = dsp_res;
  assign m_pd      = dsp_pd;
  assign busy      = |v_q;

endmodule

// File: tb/tb_dsp_share_sched.sv
// Randomized bench for dsp_share_sched with a CE-driven DSP model
// and a queue-based reference of accept order, latency and results.
module tb_dsp_share_sched;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int CW = 32;
  localparam int DW = 16;
  localparam int OW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] s_valid, s_ready;
  logic [N*AW-1:0] s_op_a;
  logic [N*BW-1:0] s_op_b;
  logic [N*CW-1:0] s_op_c;
  logic [N*DW-1:0] s_op_d;
  logic [AW-1:0] dsp_op_a;
  logic [BW-1:0] dsp_op_b;
  logic [DW-1:0] dsp_op_d;
  logic [CW-1:0] dsp_op_c;
  logic dsp_ce_s0, dsp_ce_s1, dsp_ce_s2, dsp_ce_s3;
  logic [OW-1:0] dsp_res;
  logic dsp_pd;
  logic m_valid, m_ready, m_pd, busy;
  logic [OW-1:0] m_res;
  logic [IW-1:0] m_id;

  logic signed [AW-1:0] va [N];
  logic signed [BW-1:0] vb [N];
  logic signed [CW-1:0] vc [N];
  logic signed [DW-1:0] vd [N];

  always #5 clk = ~clk;

  dsp_share_sched dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_op_a(s_op_a), .s_op_b(s_op_b),
    .s_op_c(s_op_c), .s_op_d(s_op_d),
    .dsp_op_a(dsp_op_a), .dsp_op_b(dsp_op_b),
    .dsp_op_d(dsp_op_d), .dsp_op_c(dsp_op_c),
    .dsp_ce_s0(dsp_ce_s0), .dsp_ce_s1(dsp_ce_s1),
    .dsp_ce_s2(dsp_ce_s2), .dsp_ce_s3(dsp_ce_s3),
    .dsp_res(dsp_res), .dsp_pd(dsp_pd),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_res(m_res), .m_pd(m_pd), .m_id(m_id),
    .busy(busy)
  );

  always_comb begin
    s_op_a = '0;
    s_op_b = '0;
    s_op_c = '0;
    s_op_d = '0;
    for (int i = 0; i < N; i++) begin
      s_op_a[i*AW +: AW] = va[i];
      s_op_b[i*BW +: BW] = vb[i];
      s_op_c[i*CW +: CW] = vc[i];
      s_op_d[i*DW +: DW] = vd[i];
    end
  end

  // DSP instance model: A/B/D regs, pre-adder + B1, M + C, P.
  logic signed [AW-1:0] ra, rd;
  logic signed [BW-1:0] rb, rb1;
  logic signed [AW:0]   ad;
  logic signed [32:0]   mr;
  logic signed [CW-1:0] rc;
  logic [OW-1:0]        pr = '0;

  always @(posedge clk) begin
    if (dsp_ce_s0) begin
      ra <= dsp_op_a;
      rb <= dsp_op_b;
      rd <= dsp_op_d;
    end
    if (dsp_ce_s1) begin
      ad  <= {ra[AW-1], ra} + {rd[DW-1], rd};
      rb1 <= rb;
    end
    if (dsp_ce_s2) begin
      mr <= ad * rb1;
      rc <= dsp_op_c;
    end
    if (dsp_ce_s3) pr <= mr[31:0] + rc;
  end

  assign dsp_res = pr;
  assign dsp_pd  = (pr[11:4] == 8'h34);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] calc(input logic signed [AW-1:0] a,
                                       input logic signed [BW-1:0] b,
                                       input logic signed [CW-1:0] c,
                                       input logic signed [DW-1:0] d);
    longint r;
    r = (longint'(a) + longint'(d)) * longint'(b) + longint'(c);
    return r[31:0];
  endfunction

  typedef struct {
    int id;
    logic [31:0] res;
    logic pd;
    int t;
  } item_t;

  item_t q[$];
  int mptr = 0;

  // Reference: RR order, room = fewer than 4 in flight or m_ready,
  // oldest item shows exactly 4 cycles after its accept (or later).
  always @(negedge clk) begin
    int eg;
    bit found, free, emv;
    logic [N-1:0] esr;
    item_t it;
    if (!rst_n) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ce", {dsp_ce_s0, dsp_ce_s1, dsp_ce_s2, dsp_ce_s3}, 0);
      chk("rst_s_ready", s_ready, 0);
      q.delete();
      mptr = 0;
    end else begin
      found = 0;
      eg = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (s_valid[(mptr + k) % N]) begin
          found = 1;
          eg = (mptr + k) % N;
        end
      end
      free = (q.size() < 4) || m_ready;
      esr = '0;
      if (found && free) esr[eg] = 1'b1;
      chk("s_ready", s_ready, esr);
      chk("ce_s0", dsp_ce_s0, found && free);
      emv = (q.size() > 0) && (cyc - q[0].t >= 4);
      chk("m_valid", m_valid, emv);
      chk("busy", busy, q.size() > 0);
      if (emv) begin
        chk("m_res", m_res, q[0].res);
        chk("m_pd", m_pd, q[0].pd);
        chk("m_id", m_id, q[0].id);
        if (m_ready) void'(q.pop_front());
      end
      if (found && free) begin
        it.id  = eg;
        it.res = calc(va[eg], vb[eg], vc[eg], vd[eg]);
        it.pd  = (it.res[11:4] == 8'h34);
        it.t   = cyc;
        q.push_back(it);
        mptr = (eg + 1) % N;
      end
    end
  end

  typedef struct {
    logic [31:0] res;
    logic pd;
    int id;
  } out_t;

  out_t outs[$];
  logic [N-1:0] hs;
  bit mv_s;
  logic [31:0] mres_s;
  logic [IW-1:0] mid_s;
  int scyc;

  task automatic tick();
    out_t o;
    @(negedge clk);
    hs = s_valid & s_ready;
    mv_s = m_valid;
    mres_s = m_res;
    mid_s = m_id;
    scyc = cyc;
    if (m_valid && m_ready) begin
      o.res = m_res;
      o.pd = m_pd;
      o.id = int'(m_id);
      outs.push_back(o);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) s_valid[i] = 1'b0;
  endtask

  task automatic offer(input int i, input logic signed [AW-1:0] a,
                       input logic signed [BW-1:0] b,
                       input logic signed [CW-1:0] c,
                       input logic signed [DW-1:0] d);
    va[i] = a;
    vb[i] = b;
    vc[i] = c;
    vd[i] = d;
    s_valid[i] = 1'b1;
  endtask

  task automatic offer_rand(input int i);
    offer(i, AW'($urandom), BW'($urandom), CW'($urandom), DW'($urandom));
  endtask

  task automatic drain();
    bit done;
    done = 0;
    m_ready = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      if (s_valid == '0 && !busy) done = 1;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic wait_result(input int t0, input string nm,
                             input longint ex_res, input int ex_id);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mv_s) break;
    end
    chk({nm, "_latency"}, scyc - t0, 4);
    chk({nm, "_res"}, mres_s, ex_res);
    chk({nm, "_id"}, mid_s, ex_id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, sent, t0;
    s_valid = '0;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) offer(i, '0, '0, '0, '0);
    s_valid = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // single requester, hand-computed (3+2)*-4+100 = 80
    offer(0, 16'sd3, -16'sd4, 32'sd100, 16'sd2);
    tick();
    chk("t1_accept", hs, 4'b0001);
    t0 = scyc;
    wait_result(t0, "t1", 80, 0);
    drain();

    // all requesters busy: ptr is 1 after the first accept
    for (int i = 0; i < N; i++) offer_rand(i);
    for (int s = 0; s < 16; s++) begin
      tick();
      chk("t2_grant", hs, 4'b0001 << ((1 + s) % N));
      for (int i = 0; i < N; i++) if (!s_valid[i]) offer_rand(i);
    end
    drain();

    // backpressure: six items, only four fit
    outs.delete();
    m_ready = 1'b0;
    sent = 0;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      if (!s_valid[2] && sent < 6) begin
        offer_rand(2);
        sent++;
      end
      tick();
      acc += int'(hs[2]);
    end
    chk("t3_accepted", acc, 4);
    chk("t3_s_ready", s_ready, 0);
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!s_valid[2] && sent < 6) begin
        offer_rand(2);
        sent++;
      end
      tick();
    end
    drain();
    chk("t3_outputs", outs.size(), 6);

    // bubble compression: one item every third cycle
    m_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 18; k++) begin
      if (k % 3 == 0 && !s_valid[1]) offer_rand(1);
      tick();
      acc += int'(hs[1]);
    end
    chk("t4_accepted", acc, 4);
    chk("t4_busy", busy, 1);
    chk("t4_s_ready", s_ready, 0);
    drain();

    // pattern detect: (4+4)*0x68 = 0x340, then (-3+1)*5+100 = 90
    outs.delete();
    offer(3, 16'sd4, 16'sh68, 32'sd0, 16'sd4);
    tick();
    offer(3, -16'sd3, 16'sd5, 32'sd100, 16'sd1);
    tick();
    drain();
    chk("t5_count", outs.size(), 2);
    if (outs.size() >= 2) begin
      chk("t5_res0", outs[0].res, 32'h340);
      chk("t5_pd0", outs[0].pd, 1);
      chk("t5_res1", outs[1].res, 90);
      chk("t5_pd1", outs[1].pd, 0);
    end

    // random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++)
        if (!s_valid[i] && $urandom_range(0, 1) == 1) offer_rand(i);
      tick();
    end
    drain();

    // reset with three items in flight
    for (int i = 0; i < 3; i++) offer_rand(i);
    repeat (3) tick();
    chk("t7_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_m_valid", m_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_ce", {dsp_ce_s0, dsp_ce_s1, dsp_ce_s2, dsp_ce_s3}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    offer(1, 16'sd7, 16'sd3, -32'sd5, -16'sd2);
    offer_rand(3);
    tick();
    chk("t7_ptr_reset", hs, 4'b0010);
    t0 = scyc;
    wait_result(t0, "t7", 10, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_share_sched.md
Name: dsp_share_sched

Overview:
- Round-robin scheduler that shares one signed multiply-add DSP unit among req_n requesters. The unit computes res = (a + d) * b + c.
- Arbitrates valid/ready operand streams and muxes the winner's operands into the DSP.
- Generates every per-stage clock enable, tracks stage valids and requester IDs through the 4-stage pipeline, and presents results on a valid/ready output with backpressure.
- Sits between convolution datapath requesters and the DSP instance.

Parameters:
- req_n, 4, number of requesters (2..8)
- id_width, 2, requester ID width; must be ≥ clog2(req_n)
- op_a_width, 16, signed operand A width
- op_b_width, 16, signed operand B width
- op_c_width, 32, signed operand C width
- op_d_width, 16, signed operand D width
- output_width, 32, DSP result width
- simulation_delay, 1, register assignment delay for simulation

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  req_n  per-requester operand valid
- s_ready  out  req_n  per-requester operand accept
- s_op_a  in  req_n*op_a_width  flattened A operands; requester i at slice [i*op_a_width +: op_a_width]
- s_op_b  in  req_n*op_b_width  flattened B operands
- s_op_c  in  req_n*op_c_width  flattened C operands
- s_op_d  in  req_n*op_d_width  flattened D operands
- dsp_op_a / dsp_op_b / dsp_op_d / dsp_op_c  out  operand widths  operands driven to the DSP
- dsp_ce_s0  out  1  drives the DSP A, B and D input-register enables
- dsp_ce_s1  out  1  drives the DSP pre-adder and stage-1 B enables
- dsp_ce_s2  out  1  drives the DSP multiplier and stage-2 C enables
- dsp_ce_s3  out  1  drives the DSP P-register enable
- dsp_res  in  output_width  DSP result
- dsp_pd  in  1  DSP pattern-detect result
- m_valid  out  1  result valid
- m_ready  in  1  result accept
- m_res  out  output_width  result (equals dsp_res)
- m_pd  out  1  pattern-detect flag (equals dsp_pd)
- m_id  out  id_width  ID of the requester that issued the result
- busy  out  1  high while any pipeline stage holds a valid item

Behaviour:
- DSP configuration:
  - A, B, D input registers on; pre-adder on; stage-1 B register on; stage-1 C register off.
  - C is carried inside this block: a register captures the winning C on dsp_ce_s0, moves to a second register on dsp_ce_s1, and that second register drives dsp_op_c. This aligns C with the stage-2 capture.
- Stage valids v1..v4 correspond to DSP stages s0..s3. Each stage has a tag register (ID) updated with the same enable as the stage.
- Advance logic, purely combinational:
  - mv4 = v3 & (!v4 | m_ready)
  - mv3 = v2 & (!v3 | mv4)
  - mv2 = v1 & (!v2 | mv3)
  - free1 = !v1 | mv2
  - mv1 = |(s_valid & grant) & free1
  - dsp_ce_s0 = mv1, dsp_ce_s1 = mv2, dsp_ce_s2 = mv3, dsp_ce_s3 = mv4.
- Stage valid update at each clock edge:
  - v_k is set when mv_k.
  - Otherwise v_k is cleared when the item leaves the stage (mv_{k+1}, or m_ready for v4).
  - Otherwise v_k holds.
- Outputs:
  - m_valid = v4; m_id = tag4; busy = |{v1..v4}.
  - A result stalled by m_ready low holds m_res, m_pd and m_id stable, because the DSP CEs are frozen.
- Arbitration:
  - Round-robin pointer ptr, reset to 0.
  - grant is one-hot: the first requester with s_valid asserted, searching from ptr upward with wrap.
  - s_ready[i] = grant[i] & free1; s_ready is independent of s_valid of other requesters once the grant is formed.
  - On mv1, ptr becomes (granted index + 1) mod req_n. With no accept, ptr holds.
  - Operand mux selects the granted requester. When there is no grant, the mux outputs are don't-care and CE is low.
- Latency and throughput:
  - An item accepted at edge T appears with m_valid=1 after edge T+4, provided there are no stalls.
  - Throughput is 1 item per cycle when m_ready is held high.
- Stalls and boundaries:
  - A stall compresses bubbles. While m_ready is low, stages upstream of the first empty stage keep advancing.
  - Acceptance stops only when all four stages are full.
  - m_ready rising with the pipeline full allows a new accept in the same cycle: free1 propagates combinationally.
  - A requester dropping s_valid without a handshake is a protocol violation; behaviour is undefined.
- Reset:
  - Asynchronous; clears v1..v4, all tags and ptr.
  - Outputs after reset: m_valid=0, busy=0, s_ready=0 until a valid arrives, all dsp_ce=0.
  - Reset mid-operation discards in-flight items; no m_valid is produced for them.
  - Operand and C carry registers are not reset.

Decomposition:
- Shared package holds: stage count localparam (4); stage index constants; a clog2 function used to check id_width.
- Natural sub-module: rr_arbiter (req_n-wide round-robin, ports req, accept, grant, grant_idx), reusable by other shared-resource blocks.

Test Plan:
- Single requester: a=3, d=2, b=-4, c=100, m_ready=1 -> m_valid exactly 4 cycles after accept; m_res=80, m_id=0.
- All 4 requesters continuously valid, m_ready=1 -> grants follow 0,1,2,3,0,… one per cycle; m_id sequence matches; results correct per requester.
- Backpressure: stream 6 items with m_ready=0 -> exactly 4 accepted, s_ready then 0; m_res/m_id stable; m_ready=1 -> remaining items drain in order with no loss or duplication.
- Bubble compression: accept 1 item, hold m_ready=0, feed one item every 3 cycles -> pipeline fills to 4 items before s_ready drops.
- Pattern detect: operands that make res[11:4]=8'h34 (DSP patterns as configured) -> m_pd=1 coincident with that result only.
- Reset mid-stream: assert rst_n=0 with 3 items in flight -> m_valid, busy and all dsp_ce drop immediately; after release, ptr=0 and the next single item completes with 4-cycle latency.
